text_buffer: RTL and testbench

- Character store directly upstream of the glyph renderer.
- Accepts a byte stream (UART/keyboard receiver) over a valid/ready handshake and interprets a small set of control codes.
- Holds a COLS x ROWS character grid and, for each pixel coordinate, supplies the 8-bit character code the renderer draws.
- The renderer uses bit 7 as its language select (0 = ASCII ROM, 1 = Thai ROM), so bytes 0x80–0xFF are stored and displayed as printable characters.

---
 rtl/text_buffer_if.sv | 19 +
 rtl/text_buffer.sv | 151 +++++++++++++++
 tb/tb_text_buffer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_buffer_if.sv
// Byte-stream handshake between the character receiver and the text buffer.
// The receiver drives data/valid and the buffer answers with ready.
interface text_buffer_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;

   modport master (
      output rx_data,
      output rx_valid,
      input  rx_ready
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      output rx_ready
   );
endinterface

// File: rtl/text_buffer.sv
// Character grid for the glyph renderer: consumes a byte stream with a few
// control codes and serves the character under the current pixel each cycle.
module text_buffer #(
   parameter int COLS = 32,
   parameter int ROWS = 4,
   parameter int X0   = 192,
   parameter int Y0   = 208,
   localparam int CW  = $clog2(COLS),
   localparam int RW  = $clog2(ROWS)
) (
   input  logic          clk,
   input  logic          reset_n,
   text_buffer_if.slave  rx,
   input  logic [9:0]    x,
   input  logic [9:0]    y,
   output logic [7:0]    ascii_code,
   output logic [CW-1:0] cursor_col,
   output logic [RW-1:0] cursor_row,
   output logic          busy
);
   localparam int DEPTH = COLS * ROWS;
   localparam int AW    = $clog2(DEPTH);
   localparam logic [7:0] SPACE = 8'h20;

   typedef enum logic [1:0] {CLEAR, IDLE, WRITE} state_t;

   state_t        state, state_nx;
   logic [AW-1:0] sweep_idx, sweep_nx;
   logic [CW-1:0] col_nx;
   logic [RW-1:0] row_nx;
   logic [7:0]    rx_byte, rx_byte_nx;
   logic          we;
   logic [AW-1:0] waddr;
   logic [7:0]    wdata;
   logic [7:0]    mem [DEPTH];

   logic          in_window;
   logic [CW-1:0] rd_col;
   logic [RW-1:0] rd_row;
   logic [RW-1:0] row_inc;

   function automatic logic [AW-1:0] cell_addr(input logic [CW-1:0] c, input logic [RW-1:0] r);
      return AW'(int'(r) * COLS + int'(c));
   endfunction

   assign row_inc = (cursor_row == RW'(ROWS - 1)) ? '0 : cursor_row + RW'(1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= CLEAR;
         sweep_idx  <= '0;
         cursor_col <= '0;
         cursor_row <= '0;
         rx_byte    <= '0;
      end else begin
         state      <= state_nx;
         sweep_idx  <= sweep_nx;
         cursor_col <= col_nx;
         cursor_row <= row_nx;
         rx_byte    <= rx_byte_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      sweep_nx    = sweep_idx;
      col_nx      = cursor_col;
      row_nx      = cursor_row;
      rx_byte_nx  = rx_byte;
      we          = 1'b0;
      waddr       = cell_addr(cursor_col, cursor_row);
      wdata       = rx_byte;
      rx.rx_ready = 1'b0;
      busy        = 1'b0;
      case (state)
         CLEAR: begin
            busy  = 1'b1;
            we    = 1'b1;
            waddr = sweep_idx;
            wdata = SPACE;
            if (sweep_idx == AW'(DEPTH - 1)) begin
               state_nx = IDLE;
               sweep_nx = '0;
               col_nx   = '0;
               row_nx   = '0;
            end else begin
               sweep_nx = sweep_idx + AW'(1);
            end
         end
         IDLE: begin
            rx.rx_ready = 1'b1;
            if (rx.rx_valid) begin
               rx_byte_nx = rx.rx_data;
               state_nx   = WRITE;
            end
         end
         WRITE: begin
            state_nx = IDLE;
            // Backspace blanks the cell it steps back onto; never moves past (0,0).
            if (rx_byte == 8'h08) begin
               if (cursor_col != '0 || cursor_row != '0) begin
                  if (cursor_col == '0) begin
                     col_nx = CW'(COLS - 1);
                     row_nx = cursor_row - RW'(1);
                  end else begin
                     col_nx = cursor_col - CW'(1);
                  end
                  we    = 1'b1;
                  waddr = cell_addr(col_nx, row_nx);
                  wdata = SPACE;
               end
            end else if (rx_byte == 8'h0A || rx_byte == 8'h0D) begin
               col_nx = '0;
               row_nx = row_inc;
            end else if (rx_byte == 8'h0C) begin
               state_nx = CLEAR;
            end else if (rx_byte < 8'h20 || rx_byte == 8'h7F) begin
            end else begin
               we = 1'b1;
               if (cursor_col == CW'(COLS - 1)) begin
                  col_nx = '0;
                  row_nx = row_inc;
               end else begin
                  col_nx = cursor_col + CW'(1);
               end
            end
         end
         default: state_nx = CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Pixel-side read port runs every cycle regardless of what the writer is doing.
   assign in_window = (int'(x) >= X0) && (int'(x) < X0 + 8 * COLS) &&
                      (int'(y) >= Y0) && (int'(y) < Y0 + 16 * ROWS);
   assign rd_col    = CW'((int'(x) - X0) >> 3);
   assign rd_row    = RW'((int'(y) - Y0) >> 4);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ascii_code <= SPACE;
      end else begin
         ascii_code <= in_window ? mem[cell_addr(rd_col, rd_row)] : SPACE;
      end
   end
endmodule

// File: tb/tb_text_buffer.sv
// Directed bench for text_buffer: pixel reads are scored by a separate monitor
// against a queue of hand-computed expected characters.
module tb_text_buffer;
   localparam int COLS = 32;
   localparam int ROWS = 4;
   localparam int X0   = 192;
   localparam int Y0   = 208;

   typedef struct {
      logic [7:0] code;
      int         px;
      int         py;
   } rd_exp_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [9:0] x = '0;
   logic [9:0] y = '0;
   logic [7:0] ascii_code;
   logic [4:0] cursor_col;
   logic [1:0] cursor_row;
   logic       busy;

   int         checks = 0;
   int         errors = 0;
   rd_exp_t    exp_q[$];
   logic       rd_req = 1'b0;
   logic       rd_pipe = 1'b0;

   text_buffer_if rx_if ();

   always #5 clk = ~clk;

   text_buffer #(.COLS(COLS), .ROWS(ROWS), .X0(X0), .Y0(Y0)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .rx         (rx_if),
      .x          (x),
      .y          (y),
      .ascii_code (ascii_code),
      .cursor_col (cursor_col),
      .cursor_row (cursor_row),
      .busy       (busy)
   );

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // A read issued on one cycle is answered by ascii_code one clock later.
   always @(posedge clk) rd_pipe <= rd_req;

   always @(negedge clk) begin
      rd_exp_t e;
      if (rd_pipe) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL read_unexpected: got 0x%0h expected no read", ascii_code);
         end else begin
            e = exp_q.pop_front();
            check_output($sformatf("read x=%0d y=%0d", e.px, e.py), {24'd0, ascii_code}, {24'd0, e.code});
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (!rx_if.rx_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!rx_if.rx_ready) check_output("wait_idle_timeout", 32'd0, 32'd1);
   endtask

   task automatic apply_stimulus(input logic [7:0] b);
      wait_idle();
      rx_if.rx_data  = b;
      rx_if.rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_if.rx_valid = 1'b0;
   endtask

   task automatic read_xy(input int px, input int py, input logic [7:0] code);
      rd_exp_t e;
      @(negedge clk);
      x = 10'(px);
      y = 10'(py);
      e.code = code;
      e.px   = px;
      e.py   = py;
      exp_q.push_back(e);
      rd_req = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
   endtask

   task automatic read_cell(input int c, input int r, input logic [7:0] code);
      read_xy(X0 + 8 * c + (c % 8), Y0 + 16 * r + (r * 5 % 16), code);
   endtask

   task automatic check_cursor(input string name, input int c, input int r);
      check_output({name, "_col"}, {27'd0, cursor_col}, 32'(c));
      check_output({name, "_row"}, {30'd0, cursor_row}, 32'(r));
   endtask

   task automatic count_busy(output int n);
      int t = 0;
      n = 0;
      @(negedge clk);
      while (!busy && t < 10) begin
         @(negedge clk);
         t++;
      end
      while (busy && n < 1000) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic check_all_blank(input logic [7:0] cell00);
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            read_cell(c, r, (c == 0 && r == 0) ? cell00 : 8'h20);
   endtask

   initial begin
      int n;
      rx_if.rx_data  = '0;
      rx_if.rx_valid = 1'b0;

      #12;
      check_output("reset_busy", {31'd0, busy}, 32'd1);
      check_output("reset_ready", {31'd0, rx_if.rx_ready}, 32'd0);
      check_output("reset_ascii", {24'd0, ascii_code}, 32'h20);
      check_cursor("reset_cursor", 0, 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      count_busy(n);
      check_output("initial_clear_cycles", 32'(n), 32'd128);
      check_output("ready_after_clear", {31'd0, rx_if.rx_ready}, 32'd1);
      check_output("busy_after_clear", {31'd0, busy}, 32'd0);
      check_all_blank(8'h20);
      read_xy(191, 208, 8'h20);
      read_xy(448, 208, 8'h20);
      read_xy(192, 207, 8'h20);
      read_xy(192, 272, 8'h20);

      apply_stimulus(8'h48);
      apply_stimulus(8'h69);
      wait_idle();
      check_cursor("hi_cursor", 2, 0);
      read_xy(192, 208, 8'h48);
      read_xy(200, 215, 8'h69);
      read_xy(191, 208, 8'h20);
      read_xy(199, 223, 8'h48);

      apply_stimulus(8'h08);
      wait_idle();
      check_cursor("bs1_cursor", 1, 0);
      read_cell(1, 0, 8'h20);
      read_cell(0, 0, 8'h48);
      apply_stimulus(8'h08);
      apply_stimulus(8'h08);
      wait_idle();
      check_cursor("bs_origin_cursor", 0, 0);
      read_cell(0, 0, 8'h20);

      for (int i = 0; i < 33; i++) apply_stimulus(8'h41);
      wait_idle();
      check_cursor("a33_cursor", 1, 1);
      read_cell(0, 1, 8'h41);
      read_cell(31, 0, 8'h41);
      for (int i = 33; i < 129; i++) apply_stimulus(8'h41);
      wait_idle();
      check_cursor("a129_cursor", 1, 0);

      apply_stimulus(8'hA1);
      wait_idle();
      read_cell(1, 0, 8'hA1);
      for (int i = 0; i < 3; i++) apply_stimulus(8'h0D);
      for (int i = 0; i < 5; i++) apply_stimulus(8'(8'h30 + i));
      wait_idle();
      check_cursor("pre_cr_cursor", 5, 3);
      apply_stimulus(8'h0D);
      wait_idle();
      check_cursor("cr_wrap_cursor", 0, 0);
      apply_stimulus(8'h1B);
      apply_stimulus(8'h7F);
      wait_idle();
      check_cursor("ignored_cursor", 0, 0);
      read_cell(0, 0, 8'h41);
      read_cell(2, 3, 8'h32);
      apply_stimulus(8'h0A);
      wait_idle();
      check_cursor("lf_cursor", 0, 1);
      apply_stimulus(8'h08);
      wait_idle();
      check_cursor("bs_wrap_cursor", 31, 0);
      read_cell(31, 0, 8'h20);

      apply_stimulus(8'h0C);
      rx_if.rx_data  = 8'h42;
      rx_if.rx_valid = 1'b1;
      count_busy(n);
      check_output("ff_clear_cycles", 32'(n), 32'd128);
      check_output("held_byte_ready", {31'd0, rx_if.rx_ready}, 32'd1);
      @(posedge clk);
      #1;
      rx_if.rx_valid = 1'b0;
      wait_idle();
      check_cursor("held_byte_cursor", 1, 0);
      check_all_blank(8'h42);

      for (int i = 0; i < 3; i++) apply_stimulus(8'h0D);
      apply_stimulus(8'h58);
      apply_stimulus(8'h59);
      wait_idle();
      read_cell(0, 3, 8'h58);
      apply_stimulus(8'h0C);
      n = 0;
      @(negedge clk);
      while (!busy && n < 10) begin
         @(negedge clk);
         n++;
      end
      repeat (60) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check_output("midclear_reset_busy", {31'd0, busy}, 32'd1);
      check_output("midclear_reset_ready", {31'd0, rx_if.rx_ready}, 32'd0);
      check_cursor("midclear_reset_cursor", 0, 0);
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      count_busy(n);
      check_output("restart_clear_cycles", 32'(n), 32'd128);
      check_all_blank(8'h20);

      repeat (3) @(negedge clk);
      check_output("scoreboard_drain", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: got running expected finished");
      $fatal(1, "[TB] timeout");
   end
endmodule
